// File: rtl/simd_mul_pipe.sv
// Pipelined SIMD integer multiplier: 4x8, 2x16 or 1x32-bit lanes, low or high product halves.
// PIPE_STAGES register stages from accept to result, all advancing under one global enable.
module simd_mul_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   input  logic [1:0]       sew,
   input  logic [1:0]       mode,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [TAG_W-1:0] tag_out
);

   // Exact double-width product of every lane, packed as 4x16, 2x32 or 1x64 bits.
   // Operands are extended to 2*SEW bits; the low 2*SEW product bits are then exact.
   function automatic logic [63:0] lane_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] s, input logic [1:0] m);
      logic        sa;
      logic        sb;
      logic [15:0] a8, b8;
      logic [31:0] a16, b16;
      logic [63:0] a32, b32;
      logic [63:0] p;
      sa = m[0];
      sb = (m == 2'b01);
      p  = '0;
      case (s)
         2'b00: begin
            for (int i = 0; i < 4; i++) begin
               a8 = {{8{sa & a[8*i+7]}}, a[8*i +: 8]};
               b8 = {{8{sb & b[8*i+7]}}, b[8*i +: 8]};
               p[16*i +: 16] = a8 * b8;
            end
         end
         2'b01: begin
            for (int i = 0; i < 2; i++) begin
               a16 = {{16{sa & a[16*i+15]}}, a[16*i +: 16]};
               b16 = {{16{sb & b[16*i+15]}}, b[16*i +: 16]};
               p[32*i +: 32] = a16 * b16;
            end
         end
         default: begin
            a32 = {{32{sa & a[31]}}, a};
            b32 = {{32{sb & b[31]}}, b};
            p   = a32 * b32;
         end
      endcase
      return p;
   endfunction

   // Picks the low (MUL) or high (MULH*) half of each lane product.
   function automatic logic [31:0] sel_half(input logic [63:0] p, input logic [1:0] s,
                                            input logic [1:0] m);
      logic        hi;
      logic [31:0] r;
      hi = (m != 2'b00);
      r  = '0;
      case (s)
         2'b00: begin
            for (int i = 0; i < 4; i++)
               r[8*i +: 8] = hi ? p[16*i+8 +: 8] : p[16*i +: 8];
         end
         2'b01: begin
            for (int i = 0; i < 2; i++)
               r[16*i +: 16] = hi ? p[32*i+16 +: 16] : p[32*i +: 16];
         end
         default: r = hi ? p[63:32] : p[31:0];
      endcase
      return r;
   endfunction

   // Handshake: an op is taken on an edge where in_valid & in_ready; a result is taken on an
   // edge where out_valid & out_ready. Every stage moves together when en is high.
   logic en;
   logic acc;
   logic             fin_v;
   logic [31:0]      fin_res;
   logic [TAG_W-1:0] fin_tag;

   logic             out_valid_q;
   logic [31:0]      result_q;
   logic [TAG_W-1:0] tag_out_q;

   assign en       = !out_valid_q | out_ready;
   assign in_ready = en & !flush;
   assign acc      = in_valid & in_ready;

   generate
      if (PIPE_STAGES == 1) begin : g_p1
         assign fin_v   = acc;
         assign fin_res = sel_half(lane_prod(op_a, op_b, sew, mode), sew, mode);
         assign fin_tag = tag_in;
      end else begin : g_pn
         logic             s1_v_q;
         logic [31:0]      s1_a_q, s1_b_q;
         logic [1:0]       s1_sew_q, s1_mode_q;
         logic [TAG_W-1:0] s1_tag_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_v_q    <= 1'b0;
               s1_a_q    <= '0;
               s1_b_q    <= '0;
               s1_sew_q  <= '0;
               s1_mode_q <= '0;
               s1_tag_q  <= '0;
            end else begin
               if (flush)   s1_v_q <= 1'b0;
               else if (en) s1_v_q <= acc;
               if (en) begin
                  s1_a_q    <= op_a;
                  s1_b_q    <= op_b;
                  s1_sew_q  <= sew;
                  s1_mode_q <= mode;
                  s1_tag_q  <= tag_in;
               end
            end
         end

         if (PIPE_STAGES == 2) begin : g_p2
            assign fin_v   = s1_v_q;
            assign fin_res = sel_half(lane_prod(s1_a_q, s1_b_q, s1_sew_q, s1_mode_q),
                                      s1_sew_q, s1_mode_q);
            assign fin_tag = s1_tag_q;
         end else begin : g_p3
            // Middle stage holds the raw lane products; half selection happens on the way out.
            logic             s2_v_q;
            logic [63:0]      s2_prod_q;
            logic [1:0]       s2_sew_q, s2_mode_q;
            logic [TAG_W-1:0] s2_tag_q;

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  s2_v_q    <= 1'b0;
                  s2_prod_q <= '0;
                  s2_sew_q  <= '0;
                  s2_mode_q <= '0;
                  s2_tag_q  <= '0;
               end else begin
                  if (flush)   s2_v_q <= 1'b0;
                  else if (en) s2_v_q <= s1_v_q;
                  if (en) begin
                     s2_prod_q <= lane_prod(s1_a_q, s1_b_q, s1_sew_q, s1_mode_q);
                     s2_sew_q  <= s1_sew_q;
                     s2_mode_q <= s1_mode_q;
                     s2_tag_q  <= s1_tag_q;
                  end
               end
            end

            assign fin_v   = s2_v_q;
            assign fin_res = sel_half(s2_prod_q, s2_sew_q, s2_mode_q);
            assign fin_tag = s2_tag_q;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         tag_out_q   <= '0;
      end else begin
         if (flush)   out_valid_q <= 1'b0;
         else if (en) out_valid_q <= fin_v;
         if (en) begin
            result_q  <= fin_res;
            tag_out_q <= fin_tag;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign tag_out   = tag_out_q;

endmodule
